// File: rtl/cipher_pkg.sv
// -----------------------------------------------------------------------------
// cipher_pkg
// Types and constants shared by the shift-cipher encrypt and decrypt blocks.
//   ALPHA_LEN / ALPHA_BASE : size and first code of the upper-case alphabet
//   cipher_state_t         : message framing FSM states (IDLE / RUN)
//   shift_t                : per-byte shift amount, always in 0..ALPHA_LEN-1
//   wrap_shift()           : (key + offset) reduced into the alphabet range
// -----------------------------------------------------------------------------
package cipher_pkg;

    localparam int unsigned ALPHA_LEN  = 26;
    localparam logic [7:0]  ALPHA_BASE = 8'h41;   // 'A'
    localparam int unsigned SHIFT_W    = 5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } cipher_state_t;

    typedef logic [SHIFT_W-1:0] shift_t;

    function automatic shift_t wrap_shift(input int unsigned key, input int unsigned offset);
        return shift_t'((key + offset) % ALPHA_LEN);
    endfunction

endpackage

// File: rtl/letter_unshift.sv
// -----------------------------------------------------------------------------
// letter_unshift
// Combinational mod-26 subtraction on upper-case ASCII letters.
//   in_byte  : ciphertext byte
//   shift    : amount to subtract, 0..25
//   out_byte : 'A' + ((in_byte - 'A' - shift) mod 26) for 'A'..'Z',
//              otherwise in_byte unchanged
// -----------------------------------------------------------------------------
module letter_unshift
    import cipher_pkg::*;
(
    input  logic [7:0] in_byte,
    input  shift_t     shift,
    output logic [7:0] out_byte
);

    logic       is_letter;
    logic [7:0] offset;
    logic [7:0] shift_ext;

    always_comb begin
        is_letter = (in_byte >= ALPHA_BASE) && (in_byte < (ALPHA_BASE + 8'(ALPHA_LEN)));
        offset    = in_byte - ALPHA_BASE;
        shift_ext = {3'b000, shift};
        out_byte  = in_byte;
        if (is_letter) begin
            // Add one alphabet length before subtracting when the result
            // would otherwise go below 'A'.
            if (offset >= shift_ext) begin
                out_byte = ALPHA_BASE + (offset - shift_ext);
            end else begin
                out_byte = ALPHA_BASE + (offset + 8'(ALPHA_LEN) - shift_ext);
            end
        end
    end

endmodule

// File: rtl/stream_decrypt.sv
// -----------------------------------------------------------------------------
// stream_decrypt
// Streaming shift-cipher decryptor for fixed-length messages with a single
// output register (accepts and emits in the same cycle).
//
// Parameters
//   MSG_LEN : message length in bytes (1..255)
//   KEY     : base shift (0..25)
// Ports
//   clk       : clock, all state on rising edge
//   rst_n     : asynchronous active-low reset
//   in_valid  / in_ready  / in_data  / in_last  : ciphertext input stream
//   out_valid / out_ready / out_data / out_last : plaintext output stream
//   len_err   : one-cycle pulse when in_last and the byte position disagree
//
// Configuration macro
//   STREAM_DECRYPT_ROLLING_KEY_EN : when defined the shift is (KEY + idx) mod 26,
//   otherwise KEY for every byte and idx only frames the message.
// -----------------------------------------------------------------------------
module stream_decrypt
    import cipher_pkg::*;
#(
    parameter int unsigned MSG_LEN = 23,
    parameter int unsigned KEY     = 3
)(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic       len_err
);

    // A single-byte message still needs a one-bit counter to exist.
    localparam int unsigned     IDX_W   = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
    localparam logic [IDX_W-1:0] IDX_END = IDX_W'(MSG_LEN - 1);

    cipher_state_t    state_reg, state_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic             out_valid_reg, out_valid_next;
    logic [7:0]       out_data_reg, out_data_next;
    logic             out_last_reg, out_last_next;
    logic             len_err_reg, len_err_next;

    logic             ready_int;
    logic             accept;
    logic             at_end;
    logic             msg_done;
    shift_t           shift;
    logic [7:0]       plain;

`ifdef STREAM_DECRYPT_ROLLING_KEY_EN
    assign shift = wrap_shift(KEY, 32'(idx_reg));
`else
    assign shift = wrap_shift(KEY, 0);
`endif

    letter_unshift u_unshift (
        .in_byte  (in_data),
        .shift    (shift),
        .out_byte (plain)
    );

    // The output register can take a new byte whenever it is empty or
    // being drained in this same cycle.
    assign ready_int = !out_valid_reg || out_ready;
    assign in_ready  = ready_int;

    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        out_valid_next = out_valid_reg;
        out_data_next  = out_data_reg;
        out_last_next  = out_last_reg;
        len_err_next   = 1'b0;

        accept   = in_valid && ready_int;
        at_end   = (idx_reg == IDX_END);
        // Either framing source ends the message; disagreement is an error.
        msg_done = at_end || in_last;

        if (out_ready) begin
            out_valid_next = 1'b0;
        end

        if (accept) begin
            out_valid_next = 1'b1;
            out_data_next  = plain;
            out_last_next  = msg_done;
            len_err_next   = at_end ^ in_last;
            idx_next       = msg_done ? '0 : idx_reg + IDX_W'(1);
        end

        case (state_reg)
            ST_IDLE: if (accept && !msg_done) state_next = ST_RUN;
            ST_RUN:  if (accept && msg_done)  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            idx_reg       <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= 8'h00;
            out_last_reg  <= 1'b0;
            len_err_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            out_valid_reg <= out_valid_next;
            out_data_reg  <= out_data_next;
            out_last_reg  <= out_last_next;
            len_err_reg   <= len_err_next;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_last  = out_last_reg;
    assign len_err   = len_err_reg;

endmodule

// File: tb/tb_stream_decrypt.sv
// -----------------------------------------------------------------------------
// tb_stream_decrypt
// Three decryptors (MSG_LEN 5, 23 and 1, KEY 3) share one set of stimulus
// signals; sel routes in_valid to one of them and picks its outputs.
// The reference model works on whole-byte rules: shift per position,
// mod-26 letter arithmetic, and a single-entry output register.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_stream_decrypt;

    localparam int KEY  = 3;
    localparam int NDUT = 3;
`ifdef STREAM_DECRYPT_ROLLING_KEY_EN
    localparam bit ROLL = 1'b1;
`else
    localparam bit ROLL = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic [7:0]      in_data;
    logic            in_last;
    logic            out_ready;
    logic [1:0]      sel;

    logic [NDUT-1:0] v_k, rdy_k, ov_k, ol_k, le_k;
    logic [7:0]      od_k [NDUT];

    logic            cur_in_ready, cur_out_valid, cur_out_last, cur_len_err;
    logic [7:0]      cur_out_data;

    always #5 clk = ~clk;

    assign v_k[0] = in_valid && (sel == 2'd0);
    assign v_k[1] = in_valid && (sel == 2'd1);
    assign v_k[2] = in_valid && (sel == 2'd2);

    stream_decrypt #(.MSG_LEN(5), .KEY(KEY)) dut_len5 (
        .clk(clk), .rst_n(rst_n), .in_valid(v_k[0]), .in_ready(rdy_k[0]),
        .in_data(in_data), .in_last(in_last), .out_valid(ov_k[0]),
        .out_ready(out_ready), .out_data(od_k[0]), .out_last(ol_k[0]), .len_err(le_k[0]));

    stream_decrypt #(.MSG_LEN(23), .KEY(KEY)) dut_len23 (
        .clk(clk), .rst_n(rst_n), .in_valid(v_k[1]), .in_ready(rdy_k[1]),
        .in_data(in_data), .in_last(in_last), .out_valid(ov_k[1]),
        .out_ready(out_ready), .out_data(od_k[1]), .out_last(ol_k[1]), .len_err(le_k[1]));

    stream_decrypt #(.MSG_LEN(1), .KEY(KEY)) dut_len1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v_k[2]), .in_ready(rdy_k[2]),
        .in_data(in_data), .in_last(in_last), .out_valid(ov_k[2]),
        .out_ready(out_ready), .out_data(od_k[2]), .out_last(ol_k[2]), .len_err(le_k[2]));

    always_comb begin
        cur_in_ready  = rdy_k[sel];
        cur_out_valid = ov_k[sel];
        cur_out_data  = od_k[sel];
        cur_out_last  = ol_k[sel];
        cur_len_err   = le_k[sel];
    end

    // Scoreboard / model state
    int          errors = 0;
    int          checks = 0;
    int          err_seen = 0;
    int          m_idx [NDUT];
    bit          m_ov;
    logic [7:0]  m_data;
    bit          m_last;
    bit          m_err;
    logic [7:0]  rxq [$];
    string       hello_ct;

    function automatic int len_of(input int k);
        case (k)
            0:       return 5;
            1:       return 23;
            default: return 1;
        endcase
    endfunction

    function automatic int shift_at(input int idx);
        return ROLL ? (KEY + idx) % 26 : KEY;
    endfunction

    function automatic logic [7:0] dec(input logic [7:0] c, input int idx);
        if (c >= 8'd65 && c <= 8'd90)
            return 8'(65 + ((int'(c) - 65 - shift_at(idx) + 26) % 26));
        return c;
    endfunction

    function automatic logic [7:0] enc(input logic [7:0] c, input int idx);
        if (c >= 8'd65 && c <= 8'd90)
            return 8'(65 + ((int'(c) - 65 + shift_at(idx)) % 26));
        return c;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NDUT; k++) m_idx[k] = 0;
        m_ov = 0; m_data = 8'h00; m_last = 0; m_err = 0;
    endtask

    // One clock cycle starting and ending at a falling edge.
    task automatic cycle(input logic v, input logic [7:0] d, input logic l,
                         input logic ordy, output bit acc);
        int k;
        bit at_end;
        k = int'(sel);
        in_valid = v; in_data = d; in_last = l; out_ready = ordy;
        #1;
        checks++;
        if (cur_in_ready !== (!m_ov || ordy)) begin
            errors++;
            $display("FAIL in_ready: got %b expected %b", cur_in_ready, (!m_ov || ordy));
        end
        if (cur_out_valid === 1'b1 && ordy) rxq.push_back(cur_out_data);
        acc   = v && (!m_ov || ordy);
        m_err = 0;
        if (acc) begin
            at_end   = (m_idx[k] == len_of(k) - 1);
            m_data   = dec(d, m_idx[k]);
            m_last   = at_end || l;
            m_err    = (at_end != l);
            m_ov     = 1;
            m_idx[k] = m_last ? 0 : m_idx[k] + 1;
        end else if (ordy) begin
            m_ov = 0;
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (cur_out_valid !== m_ov) begin
            errors++;
            $display("FAIL out_valid: got %b expected %b", cur_out_valid, m_ov);
        end
        if (m_ov) begin
            checks += 2;
            if (cur_out_data !== m_data) begin
                errors++;
                $display("FAIL out_data: got %h expected %h", cur_out_data, m_data);
            end
            if (cur_out_last !== m_last) begin
                errors++;
                $display("FAIL out_last: got %b expected %b", cur_out_last, m_last);
            end
        end
        checks++;
        if (cur_len_err !== m_err) begin
            errors++;
            $display("FAIL len_err: got %b expected %b", cur_len_err, m_err);
        end
        if (cur_len_err === 1'b1) err_seen++;
    endtask

    // Stream a string; last_pos marks in_last (-1 none); stall_at holds
    // out_ready low for 4 cycles while offering that byte.
    task automatic send(input string s, input int last_pos, input int stall_at, input bit rnd);
        bit   acc;
        logic v, ordy, l;
        int   tries;
        for (int i = 0; i < s.len(); i++) begin
            acc = 0;
            l   = (i == last_pos);
            if (i == stall_at)
                for (int c = 0; c < 4 && !acc; c++) cycle(1'b1, s[i], l, 1'b0, acc);
            tries = 0;
            while (!acc) begin
                v    = (!rnd || tries > 20) ? 1'b1 : ($urandom_range(0, 3) != 0);
                ordy = (!rnd || tries > 20) ? 1'b1 : ($urandom_range(0, 2) != 0);
                cycle(v, s[i], l, ordy, acc);
                tries++;
            end
        end
    endtask

    task automatic drain();
        bit acc;
        for (int c = 0; c < 3; c++) cycle(1'b0, 8'h00, 1'b0, 1'b1, acc);
    endtask

    task automatic check_rx(input string expect_s, input string name);
        checks++;
        if (rxq.size() != expect_s.len()) begin
            errors++;
            $display("FAIL %s count: got %0d expected %0d", name, rxq.size(), expect_s.len());
        end
        for (int i = 0; i < expect_s.len() && i < rxq.size(); i++) begin
            checks++;
            if (rxq[i] !== expect_s[i]) begin
                errors++;
                $display("FAIL %s byte %0d: got %h expected %h", name, i, rxq[i], expect_s[i]);
            end
        end
        $display("%s: received %0d bytes", name, rxq.size());
        rxq.delete();
    endtask

    task automatic check_err_count(input int expected, input string name);
        checks++;
        if (err_seen !== expected) begin
            errors++;
            $display("FAIL %s len_err pulses: got %0d expected %0d", name, err_seen, expected);
        end
    endtask

    task automatic check_outputs_reset(input string name);
        for (int k = 0; k < NDUT; k++) begin
            checks++;
            if (ov_k[k] !== 1'b0 || od_k[k] !== 8'h00 || ol_k[k] !== 1'b0 ||
                le_k[k] !== 1'b0 || rdy_k[k] !== 1'b1) begin
                errors++;
                $display("FAIL %s dut%0d: valid=%b data=%h last=%b err=%b ready=%b expected 0 00 0 0 1",
                         name, k, ov_k[k], od_k[k], ol_k[k], le_k[k], rdy_k[k]);
            end
        end
    endtask

    task automatic test_reset();
        sel = 2'd0; in_valid = 0; in_data = 8'h00; in_last = 0; out_ready = 1;
        rst_n = 0;
        #3;
        check_outputs_reset("reset_async");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        model_reset();
        #1;
        check_outputs_reset("reset_release");
        @(negedge clk);
        $display("test_reset done");
    endtask

    task automatic test_hello();
        sel = 2'd0; err_seen = 0;
        send(hello_ct, 4, -1, 0);
        drain();
        check_rx("HELLO", "hello");
        check_err_count(0, "hello");
    endtask

    task automatic test_round_trip();
        string pt, ct;
        pt = "HELLOWORLDFROMVIVADOAPP";
        ct = pt;
        for (int i = 0; i < pt.len(); i++) ct.putc(i, enc(pt[i], i));
        sel = 2'd1; err_seen = 0;
        for (int r = 0; r < 2; r++) begin
            send(ct, 22, -1, 1);
            drain();
            check_rx(pt, "round_trip");
        end
        check_err_count(0, "round_trip");
    endtask

    task automatic test_wrap_pass();
        string s, e;
        s = "A 7AZ";
        e = s;
        for (int i = 0; i < s.len(); i++) e.putc(i, dec(s[i], i));
        sel = 2'd0;
        send(s, 4, -1, 0);
        drain();
        checks++;
        if (rxq.size() < 1 || rxq[0] !== 8'h58) begin
            errors++;
            $display("FAIL wrap_A: got %h expected 58", (rxq.size() > 0) ? rxq[0] : 8'hxx);
        end
        check_rx(e, "wrap_pass");
    endtask

    task automatic test_backpressure();
        sel = 2'd0;
        send(hello_ct, 4, 2, 0);
        drain();
        check_rx("HELLO", "backpressure");
    endtask

    task automatic test_len_err();
        sel = 2'd0; err_seen = 0;
        send(hello_ct.substr(0, 2), 2, -1, 0);   // in_last early on byte 3
        drain();
        check_err_count(1, "early_last");
        rxq.delete();
        send(hello_ct, -1, -1, 0);               // no in_last on byte 5
        drain();
        check_err_count(2, "missing_last");
        check_rx("HELLO", "after_len_err");
    endtask

    task automatic test_msg_len_one();
        string s, e;
        int    n_err;
        logic [7:0] c;
        bit    l;
        sel = 2'd2; err_seen = 0; n_err = 0;
        s = "";
        e = "";
        for (int i = 0; i < 12; i++) begin
            c = (i % 3 == 0) ? 8'($urandom_range(32, 126)) : 8'($urandom_range(65, 90));
            l = ($urandom_range(0, 1) != 0);
            if (!l) n_err++;
            s = {s, " "};
            s.putc(i, c);
            e = {e, " "};
            e.putc(i, dec(c, 0));
            send(s.substr(i, i), l ? 0 : -1, -1, 1);
        end
        drain();
        check_rx(e, "msg_len_one");
        check_err_count(n_err, "msg_len_one");
    endtask

    task automatic test_reset_mid();
        sel = 2'd0;
        send(hello_ct.substr(0, 1), -1, -1, 0);
        in_valid = 0;
        #2;
        rst_n = 0;
        #1;
        check_outputs_reset("reset_mid");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        model_reset();
        rxq.delete();
        send(hello_ct, 4, -1, 0);
        drain();
        check_rx("HELLO", "after_reset_mid");
    endtask

    initial begin
        hello_ct = ROLL ? "KIQRV" : "KHOOR";
        model_reset();
        test_reset();
        test_hello();
        test_round_trip();
        test_wrap_pass();
        test_backpressure();
        test_len_err();
        test_msg_len_one();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stream_decrypt.md
STREAM_DECRYPT -- requirements
Module: stream_decrypt

Interface
REQ-001 SHALL have parameter MSG_LEN, default 23, message length in bytes (1..255).
REQ-002 SHALL have parameter KEY, default 3, base shift (0..25).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  ciphertext byte offered.
REQ-006 SHALL have port in_ready  output  1  block accepts byte this cycle.
REQ-007 SHALL have port in_data  input  8  ciphertext byte (ASCII).
REQ-008 SHALL have port in_last  input  1  sender marks final byte of message.
REQ-009 SHALL have port out_valid  output  1  plaintext byte available.
REQ-010 SHALL have port out_ready  input  1  sink accepts byte.
REQ-011 SHALL have port out_data  output  8  decrypted byte.
REQ-012 SHALL have port out_last  output  1  byte is position MSG_LEN-1.
REQ-013 SHALL have port len_err  output  1  one-cycle pulse on message-length mismatch.

Function
REQ-014 SHALL transfer a byte on a port only when valid and ready are both high on a clk edge.
REQ-015 SHALL drive in_ready = !out_valid || out_ready (single output register, accept and emit in the same cycle).
REQ-016 SHALL register out_data exactly 1 cycle after input transfer; out_data/out_last SHALL hold stable while out_valid && !out_ready.
REQ-017 SHALL, for in_data in 'A'..'Z', output 'A' + ((in_data - 'A' - shift) mod 26), result always in 'A'..'Z'.
REQ-018 SHALL pass every other byte value unchanged, while still advancing the position counter.
REQ-019 SHALL keep position counter idx, width clog2(MSG_LEN), incrementing per accepted byte and wrapping from MSG_LEN-1 to 0.
REQ-020 SHALL run FSM IDLE (idx=0, no byte yet) -> RUN on first accepted byte -> IDLE after accepting byte at idx=MSG_LEN-1.
REQ-021 SHALL assert out_last with the byte accepted at idx=MSG_LEN-1.
REQ-022 SHALL, if in_last is accepted at idx != MSG_LEN-1, output that byte with out_last=1, pulse len_err the next cycle, and return to IDLE with idx=0.
REQ-023 SHALL, if byte at idx=MSG_LEN-1 arrives with in_last=0, still finish the message, pulse len_err, and return to IDLE.
REQ-024 SHALL support MSG_LEN=1: every byte is the last, FSM stays in IDLE.

Reset
REQ-025 SHALL on rst_n low, immediately and asynchronously force: out_valid=0, out_data=8'h00, out_last=0, len_err=0, idx=0, FSM=IDLE.
REQ-026 SHALL discard any partial message when reset is asserted mid-operation; the first byte after release is idx 0.
REQ-027 SHALL drive in_ready=1 while in reset and in the cycle after release.

Configuration
REQ-028 SHALL honour macro STREAM_DECRYPT_ROLLING_KEY_EN: when defined, shift = (KEY + idx) mod 26; when undefined, shift = KEY for every position and idx only drives out_last/len_err.

Structure
REQ-029 SHALL take ALPHA_LEN (26), ALPHA_BASE ('A'), the FSM state enum and the shift-width typedef from shared package cipher_pkg, which the encrypt and decrypt modules also use.
REQ-030 SHALL place the mod-26 letter subtraction in combinational sub-module letter_unshift (byte, shift in; byte out).

Verification (KEY=3, rolling enabled unless noted)
REQ-031 SHALL check MSG_LEN=5, input "KIQRV" with in_last on byte 5, out_ready=1 -> output "HELLO", out_last on byte 5, len_err never set.
REQ-032 SHALL check MSG_LEN=23 round trip: encrypt output of "HELLOWORLDFROMVIVADOAPP" streamed in -> identical plaintext out; with rolling key off, "KHOOR" -> "HELLO".
REQ-033 SHALL check wrap and pass-through: 'A' at idx 0 -> 'X'; ' ' and '7' -> unchanged, with idx still advancing.
REQ-034 SHALL check backpressure: out_ready low for 4 cycles mid-message -> in_ready low, out_data held, no bytes lost or duplicated.
REQ-035 SHALL check length errors: in_last on byte 3 of MSG_LEN=5 -> out_last on byte 3, len_err pulse, next message begins at idx 0.
REQ-036 SHALL check reset mid-message: rst_n low after byte 2 -> outputs zero at once; after release "KIQRV" -> "HELLO".
